// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven time/date editor feeding set values, a load strobe
// and the run enable into the clock/calendar counter chain.
module time_set_ctrl #(
    parameter int          YEAR_MIN       = 2000,
    parameter int          YEAR_MAX       = 2047,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        set_12_24,
    input  logic [6:0]  cur_sec,
    input  logic [6:0]  cur_min,
    input  logic [6:0]  cur_hour,
    input  logic [6:0]  cur_day,
    input  logic [6:0]  cur_month,
    input  logic [10:0] cur_year,
    output logic [6:0]  set_numb_sec,
    output logic [6:0]  set_numb_min,
    output logic [6:0]  set_numb_hour,
    output logic [6:0]  set_numb_day,
    output logic [6:0]  set_numb_month,
    output logic [10:0] set_numb_year,
    output logic        load,
    output logic        en,
    output logic [2:0]  field_sel
);
    typedef enum logic [2:0] {
        ST_RUN, ST_HOUR, ST_MIN, ST_SEC, ST_DAY, ST_MONTH, ST_YEAR, ST_COMMIT
    } state_t;

    state_t      state_q;
    logic        mode_q, inc_q, dec_q, load_q, en_q;
    logic [6:0]  sec_q, min_q, hour_q, day_q, month_q;
    logic [10:0] year_q;
    logic [31:0] tmo_q;
    logic        rise_mode, rise_inc, rise_dec, any_rise;
    logic [6:0]  md;
    logic [10:0] cur_v, lo, hi, field_d;

    function automatic logic [6:0] max_day(input logic [6:0] m, input logic [10:0] y);
        logic leap;
        leap = ((y % 11'd4 == 11'd0) && (y % 11'd100 != 11'd0)) || (y % 11'd400 == 11'd0);
        case (m)
            7'd4, 7'd6, 7'd9, 7'd11: max_day = 7'd30;
            7'd2:                    max_day = leap ? 7'd29 : 7'd28;
            default:                 max_day = 7'd31;
        endcase
    endfunction

    assign rise_mode = btn_mode & ~mode_q;
    assign rise_inc  = btn_inc & ~inc_q;
    assign rise_dec  = btn_dec & ~dec_q;
    assign any_rise  = rise_mode | rise_inc | rise_dec;

    // Select the field being edited with its inclusive range, then wrap-step it.
    always_comb begin
        md    = max_day(month_q, year_q);
        cur_v = 11'd0;
        lo    = 11'd0;
        hi    = 11'd0;
        case (state_q)
            ST_HOUR: begin
                cur_v = {4'd0, hour_q};
                lo    = set_12_24 ? 11'd1 : 11'd0;
                hi    = set_12_24 ? 11'd12 : 11'd23;
            end
            ST_MIN: begin
                cur_v = {4'd0, min_q};
                hi    = 11'd59;
            end
            ST_SEC: begin
                cur_v = {4'd0, sec_q};
                hi    = 11'd59;
            end
            ST_DAY: begin
                cur_v = {4'd0, day_q};
                lo    = 11'd1;
                hi    = {4'd0, md};
            end
            ST_MONTH: begin
                cur_v = {4'd0, month_q};
                lo    = 11'd1;
                hi    = 11'd12;
            end
            ST_YEAR: begin
                cur_v = year_q;
                lo    = 11'(YEAR_MIN);
                hi    = 11'(YEAR_MAX);
            end
            default: ;
        endcase
        field_d = rise_inc ? ((cur_v >= hi) ? lo : cur_v + 11'd1)
                           : ((cur_v <= lo) ? hi : cur_v - 11'd1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            mode_q  <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            load_q  <= 1'b0;
            en_q    <= 1'b1;
            sec_q   <= 7'd0;
            min_q   <= 7'd0;
            hour_q  <= 7'd0;
            day_q   <= 7'd1;
            month_q <= 7'd1;
            year_q  <= 11'(YEAR_MIN);
            tmo_q   <= 32'd0;
        end else begin
            mode_q <= btn_mode;
            inc_q  <= btn_inc;
            dec_q  <= btn_dec;
            case (state_q)
                ST_RUN: begin
                    load_q <= 1'b0;
                    tmo_q  <= 32'd0;
                    if (rise_mode) begin
                        sec_q   <= cur_sec;
                        min_q   <= cur_min;
                        hour_q  <= cur_hour;
                        day_q   <= cur_day;
                        month_q <= cur_month;
                        year_q  <= cur_year;
                        state_q <= ST_HOUR;
                        en_q    <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    load_q  <= 1'b0;
                    en_q    <= 1'b1;
                    state_q <= ST_RUN;
                end
                default: begin
                    if (rise_mode) begin
                        tmo_q   <= 32'd0;
                        state_q <= state_t'(state_q + 3'd1);
                        if (state_q == ST_YEAR) begin
                            load_q <= 1'b1;
                            if (day_q > md) day_q <= md;
                        end
                    end else if (any_rise) begin
                        tmo_q <= 32'd0;
                        if (rise_inc ^ rise_dec) begin
                            case (state_q)
                                ST_HOUR:  hour_q  <= field_d[6:0];
                                ST_MIN:   min_q   <= field_d[6:0];
                                ST_SEC:   sec_q   <= field_d[6:0];
                                ST_DAY:   day_q   <= field_d[6:0];
                                ST_MONTH: month_q <= field_d[6:0];
                                default:  year_q  <= field_d;
                            endcase
                        end
                    end else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
                        tmo_q   <= 32'd0;
                        state_q <= ST_RUN;
                        en_q    <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
            endcase
        end
    end

    assign set_numb_sec   = sec_q;
    assign set_numb_min   = min_q;
    assign set_numb_hour  = hour_q;
    assign set_numb_day   = day_q;
    assign set_numb_month = month_q;
    assign set_numb_year  = year_q;
    assign load           = load_q;
    assign en             = en_q;
    assign field_sel      = state_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed checks of time_set_ctrl editing, wrapping, commit clamp,
// button conflicts, timeout and asynchronous reset abort.
module tb_time_set_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, set_12_24 = 1'b0;
    logic [6:0]  cur_sec = 7'd7, cur_min = 7'd5, cur_hour = 7'd23;
    logic [6:0]  cur_day = 7'd31, cur_month = 7'd1;
    logic [10:0] cur_year = 11'd2023;
    logic [6:0]  set_numb_sec, set_numb_min, set_numb_hour, set_numb_day, set_numb_month;
    logic [10:0] set_numb_year;
    logic        load, en;
    logic [2:0]  field_sel;
    int          n_run = 0, n_fail = 0;
    logic        saw_load;

    time_set_ctrl #(.YEAR_MIN(2000), .YEAR_MAX(2047), .TIMEOUT_CYCLES(32'd16)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .set_12_24(set_12_24), .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
        .cur_day(cur_day), .cur_month(cur_month), .cur_year(cur_year),
        .set_numb_sec(set_numb_sec), .set_numb_min(set_numb_min),
        .set_numb_hour(set_numb_hour), .set_numb_day(set_numb_day),
        .set_numb_month(set_numb_month), .set_numb_year(set_numb_year),
        .load(load), .en(en), .field_sel(field_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one button combination for one clock edge; returns at the following negedge.
    task automatic press(input logic m, input logic i, input logic d);
        @(negedge clk);
        btn_mode = m;
        btn_inc  = i;
        btn_dec  = d;
        @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_fs"}, 32'(field_sel), 0);
        chk({tag, "_en"}, 32'(en), 1);
        chk({tag, "_ld"}, 32'(load), 0);
        chk({tag, "_sec"}, 32'(set_numb_sec), 0);
        chk({tag, "_hour"}, 32'(set_numb_hour), 0);
        chk({tag, "_day"}, 32'(set_numb_day), 1);
        chk({tag, "_mon"}, 32'(set_numb_month), 1);
        chk({tag, "_year"}, 32'(set_numb_year), 2000);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_vals("rst_hold");
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_rel");

        // 24 h capture and hour wrap
        press(1, 0, 0);
        chk("cap_fs", 32'(field_sel), 1);
        chk("cap_en", 32'(en), 0);
        chk("cap_hour", 32'(set_numb_hour), 23);
        chk("cap_min", 32'(set_numb_min), 5);
        chk("cap_year", 32'(set_numb_year), 2023);
        press(0, 1, 0);
        chk("h24_inc_wrap", 32'(set_numb_hour), 0);
        press(0, 0, 1);
        chk("h24_dec_wrap", 32'(set_numb_hour), 23);

        // conflicts in MIN / SEC
        press(1, 0, 0);
        chk("min_fs", 32'(field_sel), 2);
        press(0, 1, 1);
        chk("incdec_nochg", 32'(set_numb_min), 5);
        press(1, 1, 0);
        chk("modeinc_fs", 32'(field_sel), 3);
        chk("modeinc_min", 32'(set_numb_min), 5);
        chk("modeinc_sec", 32'(set_numb_sec), 7);
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (10) @(negedge clk);
        btn_inc = 1'b0;
        chk("held_inc", 32'(set_numb_sec), 8);

        // DAY -> MONTH (Feb) -> YEAR -> COMMIT with clamp, year 2023
        press(1, 0, 0);
        chk("day_fs", 32'(field_sel), 4);
        press(1, 0, 0);
        press(0, 1, 0);
        chk("month_inc", 32'(set_numb_month), 2);
        press(1, 0, 0);
        chk("year_fs", 32'(field_sel), 6);
        chk("year_ld", 32'(load), 0);
        press(1, 0, 0);
        chk("c23_fs", 32'(field_sel), 7);
        chk("c23_ld", 32'(load), 1);
        chk("c23_en", 32'(en), 0);
        chk("c23_day", 32'(set_numb_day), 28);
        @(negedge clk);
        chk("c23_ld_off", 32'(load), 0);
        chk("c23_en_on", 32'(en), 1);
        chk("c23_fs_run", 32'(field_sel), 0);
        chk("c23_day_hold", 32'(set_numb_day), 28);

        // 12 h wrap, then leap-year commit, year 2024
        set_12_24 = 1'b1;
        cur_hour  = 7'd12;
        cur_day   = 7'd31;
        cur_month = 7'd1;
        cur_year  = 11'd2024;
        press(1, 0, 0);
        chk("h12_cap", 32'(set_numb_hour), 12);
        press(0, 1, 0);
        chk("h12_inc_wrap", 32'(set_numb_hour), 1);
        press(0, 0, 1);
        chk("h12_dec_wrap", 32'(set_numb_hour), 12);
        repeat (4) press(1, 0, 0);
        chk("c24_month_fs", 32'(field_sel), 5);
        press(0, 1, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        chk("c24_ld", 32'(load), 1);
        chk("c24_day", 32'(set_numb_day), 29);
        @(negedge clk);
        chk("c24_ld_off", 32'(load), 0);

        // day wrap in April, year wraps, then timeout from YEAR
        cur_year  = 11'd2047;
        cur_month = 7'd4;
        cur_day   = 7'd30;
        repeat (4) press(1, 0, 0);
        chk("apr_day_fs", 32'(field_sel), 4);
        press(0, 1, 0);
        chk("apr_day_wrap", 32'(set_numb_day), 1);
        press(1, 0, 0);
        press(1, 0, 0);
        press(0, 1, 0);
        chk("year_inc_wrap", 32'(set_numb_year), 2000);
        press(0, 0, 1);
        chk("year_dec_wrap", 32'(set_numb_year), 2047);
        saw_load = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            saw_load = saw_load | load;
        end
        chk("tmo_before", 32'(field_sel), 6);
        @(negedge clk);
        saw_load = saw_load | load;
        chk("tmo_fs", 32'(field_sel), 0);
        chk("tmo_en", 32'(en), 1);
        chk("tmo_no_load", 32'(saw_load), 0);
        chk("tmo_year_kept", 32'(set_numb_year), 2047);

        // captured out-of-range hour in 12 h mode, then reset mid-MONTH
        cur_hour = 7'd0;
        press(1, 0, 0);
        press(0, 1, 0);
        chk("h12_norm", 32'(set_numb_hour), 1);
        repeat (4) press(1, 0, 0);
        chk("abort_fs", 32'(field_sel), 5);
        #2 rst = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ld", 32'(load), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Button-driven time/date setting controller: the input side of the clock/calendar counter chain.
- Turns debounced mode/inc/dec buttons into edited set values (sec, min, hour, day, month, year), a one-cycle load strobe and the counter enable.
- Seeds editing from the counters' current binary values; clamps and wraps every field to its calendar range, including leap years.

Parameters:
- YEAR_MIN, 2000, lowest settable year
- YEAR_MAX, 2047, highest settable year (must fit 11 bits)
- TIMEOUT_CYCLES, 32'd50_000_000, idle cycles in an edit state before editing is abandoned

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- btn_mode  in  1  debounced level, next-field / enter edit
- btn_inc  in  1  debounced level, increment current field
- btn_dec  in  1  debounced level, decrement current field
- set_12_24  in  1  1 = 12-hour hour range, 0 = 24-hour
- cur_sec, cur_min, cur_hour, cur_day, cur_month  in  7 each  live counter values
- cur_year  in  11  live year
- set_numb_sec, set_numb_min, set_numb_hour, set_numb_day, set_numb_month  out  7 each  edited values
- set_numb_year  out  11  edited year
- load  out  1  one-cycle commit strobe
- en  out  1  counter enable, 0 while editing
- field_sel  out  3  0 run, 1 hour, 2 min, 3 sec, 4 day, 5 month, 6 year, 7 commit

Behaviour:
- **Reset (rst=0, async)**
  - State RUN, en=1, load=0, field_sel=0.
  - set_numb_sec=0, set_numb_min=0, set_numb_hour=0, set_numb_day=1, set_numb_month=1, set_numb_year=YEAR_MIN.
  - Button history regs and timeout counter cleared.
- **Edge detect**
  - btn_x_q registered each clk; rise_x = btn_x & ~btn_x_q, combinational.
  - Actions take effect on the same rising clk edge at which the button is first sampled high.
  - A held button produces exactly one action.
- **Priority**
  - rise_mode overrides inc/dec in the same cycle.
  - rise_inc and rise_dec together: no change, but the timeout is still restarted.
- **FSM**
  - RUN: en=1. On rise_mode, capture all cur_* into the set regs, go to HOUR, en=0.
  - Edit order on rise_mode: HOUR -> MIN -> SEC -> DAY -> MONTH -> YEAR -> COMMIT.
  - COMMIT lasts one cycle:
    - If day > max_day(month, year), day = max_day, written on this edge.
    - load=1 in this cycle, with clamped values stable on the set outputs.
    - Next state RUN, where en=1.
  - Captured values leave RUN at the same edge as the rise_mode; load and en are registered outputs.
- **Field ranges (inclusive)**
  - sec 0..59, min 0..59.
  - hour 0..23, or 1..12 if set_12_24=1.
  - day 1..max_day, month 1..12, year YEAR_MIN..YEAR_MAX.
- **inc / dec wrap**
  - inc: value >= max -> min, else +1.
  - dec: value <= min -> max, else -1.
  - This also normalises out-of-range captured values: captured 0 in 12 h mode, inc -> 1.
- **max_day**
  - 31 for months 1, 3, 5, 7, 8, 10, 12; 30 for months 4, 6, 9, 11.
  - February: 29 if leap, else 28. Leap = (y%4==0 && y%100!=0) || y%400==0.
  - Out-of-range month -> 31.
  - The day field uses the current max_day while editing DAY.
- **Timeout**
  - Counter runs in edit states (HOUR..YEAR) and restarts on any rise_*.
  - On reaching TIMEOUT_CYCLES-1: return to RUN, load stays 0, en=1.
  - Set regs keep their edited values but are not loaded.
- **Reset mid-edit:** immediate return to reset values; no load pulse.
- **Outputs during RUN:** set_numb_* hold their last values.

Test Plan:
1. **Hour wrap, 24 h.** Reset; cur_hour=23, set_12_24=0. Pulse mode, then inc. -> field_sel=1, en=0, set_numb_hour=0.
2. **Hour wrap, 12 h.** set_12_24=1, captured hour=12: inc -> 1; dec from 1 -> 12.
3. **Full commit path with day clamp.**
   - Stimulus: capture day=31, month=1, year=2023; step to MONTH; inc -> month=2; mode x2 to COMMIT.
   - Response: set_numb_day=28 and load=1 for exactly one cycle; next cycle en=1, field_sel=0.
   - Repeat with year=2024 -> day=29.
4. **Year wrap and DAY-field wrap.**
   - In YEAR field: year=2047, inc -> 2000; dec from 2000 -> 2047.
   - In DAY field with month=4: day=30, inc -> 1.
5. **Button conflicts.**
   - inc+dec same cycle: value unchanged.
   - mode+inc same cycle in MIN: advance to SEC, min unchanged.
   - inc held 10 cycles: +1 only.
6. **Timeout and reset abort.**
   - TIMEOUT_CYCLES=16: enter edit, no buttons for 16 cycles -> RUN, en=1, load never asserted.
   - rst low mid-MONTH -> all outputs at reset values asynchronously.
